// File: rtl/fp_int32_to_fp_pkg.sv
// Shared constants and format helpers for the int32 -> IEEE-754 conversion path.
package fp_cvt_pkg;

  typedef logic [1:0] rm_t;

  localparam rm_t RM_RN = 2'd0;
  localparam rm_t RM_RZ = 2'd1;
  localparam rm_t RM_RP = 2'd2;
  localparam rm_t RM_RM = 2'd3;

  function automatic int fw_of(input int w);
    return (w == 64) ? 52 : 23;
  endfunction

  function automatic int ew_of(input int w);
    return (w == 64) ? 11 : 8;
  endfunction

  function automatic int bias_of(input int w);
    return (w == 64) ? 1023 : 127;
  endfunction

endpackage

// File: rtl/fp_int32_to_fp_if.sv
// Operand/result handshake bundle for the int32 -> float converter.
interface fp_int32_to_fp_if #(parameter int W = 32);
  import fp_cvt_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  rm_t          rm;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         inexact;

  modport slave (
    input  in_valid, in_data, rm, flush, out_ready,
    output in_ready, out_valid, out_data, inexact
  );

  modport master (
    output in_valid, in_data, rm, flush, out_ready,
    input  in_ready, out_valid, out_data, inexact
  );

endinterface

// File: rtl/fp_int32_to_fp_clz.sv
// Combinational 32-bit leading-zero counter; result is 0 for an all-zero input.
module count_leading_zeros32 (
  input  logic [31:0] a_i,
  output logic [4:0]  cnt_o
);

  always_comb begin
    logic found;
    cnt_o = '0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && a_i[i]) begin
        cnt_o = 5'(31 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_int32_to_fp.sv
// Three-stage int32 -> single/double converter (capture/abs, normalize, round/pack)
// with one global stall and a synchronous flush.
module fp_int32_to_fp
  import fp_cvt_pkg::*;
#(
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  fp_int32_to_fp_if.slave   bus
);

  localparam int FW   = fw_of(W);
  localparam int EW   = ew_of(W);
  localparam int BIAS = bias_of(W);

  logic          stall;

  logic          s1_valid_q;
  logic          s1_sign_q;
  logic          s1_zero_q;
  logic [31:0]   s1_mag_q;
  rm_t           s1_rm_q;

  logic          s2_valid_q;
  logic          s2_sign_q;
  logic          s2_zero_q;
  logic [30:0]   s2_n_q;
  logic [EW-1:0] s2_e_q;
  rm_t           s2_rm_q;

  logic          out_valid_q;
  logic [W-1:0]  out_q;
  logic          inx_q;

  logic [4:0]    lz;
  logic [30:0]   s2_n_d;
  logic [EW-1:0] s2_e_d;
  logic [W-1:0]  out_d;
  logic          inx_d;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  count_leading_zeros32 u_clz (
    .a_i   (s1_mag_q),
    .cnt_o (lz)
  );

  // The leading one lands at bit 31 and is implicit in the encoding, so it is dropped here.
  assign s2_n_d = 31'(s1_mag_q << lz);
  assign s2_e_d = EW'(BIAS + 31 - int'(lz));

  if (W == 32) begin : g_single
    logic [22:0] frac;
    logic        g;
    logic        s;
    logic        inc;
    logic [23:0] frac_sum;
    logic [7:0]  e_r;

    always_comb begin
      frac = s2_n_q[30:8];
      g    = s2_n_q[7];
      s    = |s2_n_q[6:0];
      inc  = 1'b0;
      case (s2_rm_q)
        RM_RN:   inc = g & (s | frac[0]);
        RM_RZ:   inc = 1'b0;
        RM_RP:   inc = ~s2_sign_q & (g | s);
        default: inc = s2_sign_q & (g | s);
      endcase
      // Mantissa carry-out bumps the exponent; max exponent 158 cannot reach infinity.
      frac_sum = {1'b0, frac} + 24'(inc);
      e_r      = s2_e_q + 8'(frac_sum[23]);
      out_d    = {s2_sign_q, e_r, frac_sum[22:0]};
      inx_d    = g | s;
      if (s2_zero_q) begin
        out_d = '0;
        inx_d = 1'b0;
      end
    end
  end else begin : g_double
    always_comb begin
      out_d = {s2_sign_q, s2_e_q, s2_n_q, {(FW - 31){1'b0}}};
      inx_d = 1'b0;
      if (s2_zero_q) out_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_rm_q     <= RM_RN;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_n_q      <= '0;
      s2_e_q      <= '0;
      s2_rm_q     <= RM_RN;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      inx_q       <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q  <= bus.in_valid;
      s1_sign_q   <= bus.in_data[31];
      s1_zero_q   <= (bus.in_data == 32'd0);
      s1_mag_q    <= bus.in_data[31] ? (32'd0 - bus.in_data) : bus.in_data;
      s1_rm_q     <= bus.rm;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_zero_q   <= s1_zero_q;
      s2_n_q      <= s2_n_d;
      s2_e_q      <= s2_e_d;
      s2_rm_q     <= s1_rm_q;
      out_valid_q <= s2_valid_q;
      out_q       <= out_d;
      inx_q       <= inx_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fp_int32_to_fp.sv
// Directed bench driving a single- and a double-format converter from one shared stimulus.
module tb_fp_int32_to_fp;
  import fp_cvt_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  rm_t         rm;
  logic        flush;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  fp_int32_to_fp_if #(.W(32)) b32 ();
  fp_int32_to_fp_if #(.W(64)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_data   = in_data;
  assign b32.rm        = rm;
  assign b32.flush     = flush;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_data   = in_data;
  assign b64.rm        = rm;
  assign b64.flush     = flush;
  assign b64.out_ready = out_ready;

  fp_int32_to_fp #(.W(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32.slave));
  fp_int32_to_fp #(.W(64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(b64.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated operation: present for one cycle, expect the result after the third edge.
  task automatic op(input logic [31:0] v, input rm_t m, input logic [31:0] e32,
                    input logic x32, input logic [63:0] e64, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_data = v; rm = m;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk({tag, ".lat"}, 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, ".v32"}, 64'(b32.out_valid), 64'd1);
    chk({tag, ".o32"}, 64'(b32.out_data), 64'(e32));
    chk({tag, ".x32"}, 64'(b32.inexact), 64'(x32));
    chk({tag, ".v64"}, 64'(b64.out_valid), 64'd1);
    chk({tag, ".o64"}, b64.out_data, e64);
    chk({tag, ".x64"}, 64'(b64.inexact), 64'd0);
  endtask

  logic [31:0] bp_in  [5];
  logic [31:0] bp_exp [5];
  int tx, rx, stalls;

  initial begin
    bp_in  = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    bp_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; rm = RM_RN; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.valid", 64'(b32.out_valid), 64'd0);
    chk("rst.ready", 64'(b32.in_ready), 64'd1);
    chk("rst.out",   64'(b32.out_data), 64'd0);
    chk("rst.inx",   64'(b32.inexact), 64'd0);
    chk("rst.out64", b64.out_data, 64'd0);
    reset_n = 1'b1;

    // back-to-back 1, -1, 0
    @(negedge clk); in_valid = 1'b1; in_data = 32'd1;
    @(negedge clk); in_data = 32'hFFFFFFFF;
    @(negedge clk); in_data = 32'd0;
    chk("b2b.lat", 64'(b32.out_valid), 64'd0);
    @(negedge clk); in_valid = 1'b0; in_data = '0;
    chk("b2b.v0", 64'(b32.out_valid), 64'd1);
    chk("b2b.o0", 64'(b32.out_data), 64'h3F800000);
    chk("b2b.x0", 64'(b32.inexact), 64'd0);
    chk("b2b.d0", b64.out_data, 64'h3FF0000000000000);
    @(negedge clk);
    chk("b2b.v1", 64'(b32.out_valid), 64'd1);
    chk("b2b.o1", 64'(b32.out_data), 64'hBF800000);
    chk("b2b.x1", 64'(b32.inexact), 64'd0);
    chk("b2b.d1", b64.out_data, 64'hBFF0000000000000);
    @(negedge clk);
    chk("b2b.v2", 64'(b32.out_valid), 64'd1);
    chk("b2b.o2", 64'(b32.out_data), 64'h00000000);
    chk("b2b.x2", 64'(b32.inexact), 64'd0);
    chk("b2b.d2", b64.out_data, 64'h0);

    // rounding corners
    op(32'h7FFFFFFF, RM_RN, 32'h4F000000, 1'b1, 64'h41DFFFFFFFC00000, "max.rn");
    op(32'h7FFFFFFF, RM_RZ, 32'h4EFFFFFF, 1'b1, 64'h41DFFFFFFFC00000, "max.rz");
    op(32'h01000001, RM_RN, 32'h4B800000, 1'b1, 64'h4170000010000000, "tie.rn");
    op(32'h01000001, RM_RP, 32'h4B800001, 1'b1, 64'h4170000010000000, "tie.rp");
    op(32'hFEFFFFFF, RM_RM, 32'hCB800001, 1'b1, 64'hC170000010000000, "neg.rm");
    op(32'hFEFFFFFF, RM_RP, 32'hCB800000, 1'b1, 64'hC170000010000000, "neg.rp");
    op(32'h80000000, RM_RN, 32'hCF000000, 1'b0, 64'hC1E0000000000000, "min.rn");
    op(32'd1,        RM_RM, 32'h3F800000, 1'b0, 64'h3FF0000000000000, "one.rm");
    op(32'd0,        RM_RP, 32'h00000000, 1'b0, 64'h0,                "zero.rp");

    // backpressure: five ops, consumer stalls four cycles
    tx = 0; rx = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (tx < 5);
      if (tx < 5) in_data = bp_in[tx];
      rm = RM_RN;
      #1;
      if (b32.out_valid && !out_ready) begin
        stalls++;
        chk("bp.in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp.hold", 64'(b32.out_data), 64'(bp_exp[rx]));
      end
      if (b32.out_valid && out_ready) begin
        chk("bp.data", 64'(b32.out_data), 64'(bp_exp[rx]));
        rx++;
      end
      if (in_valid && b32.in_ready) tx++;
    end
    chk("bp.count", 64'(rx), 64'd5);
    chk("bp.stalls", 64'(stalls), 64'd4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.drain", 64'(b32.out_valid), 64'd0);

    // flush with three ops in flight plus a same-cycle input
    @(negedge clk); in_valid = 1'b1; in_data = 32'd10;
    @(negedge clk); in_data = 32'd11;
    @(negedge clk); in_data = 32'd12;
    @(negedge clk); in_data = 32'd13; flush = 1'b1;
    #1;
    chk("fl.busy", 64'(b32.out_valid), 64'd1);
    chk("fl.in_ready", 64'(b32.in_ready), 64'd1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; in_data = '0;
    chk("fl.q0", 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    chk("fl.q1", 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    chk("fl.q2", 64'(b32.out_valid), 64'd0);
    op(32'd7, RM_RN, 32'h40E00000, 1'b0, 64'h401C000000000000, "fl.after");

    // asynchronous reset mid-stream
    @(negedge clk); in_valid = 1'b1; in_data = 32'h7FFFFFFF; rm = RM_RN;
    @(negedge clk); in_data = 32'd5;
    @(negedge clk); in_data = 32'd6;
    @(negedge clk); in_valid = 1'b0; in_data = '0;
    chk("rs.pre_v", 64'(b32.out_valid), 64'd1);
    chk("rs.pre_x", 64'(b32.inexact), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs.valid", 64'(b32.out_valid), 64'd0);
    chk("rs.out",   64'(b32.out_data), 64'd0);
    chk("rs.inx",   64'(b32.inexact), 64'd0);
    chk("rs.ready", 64'(b32.in_ready), 64'd1);
    chk("rs.out64", b64.out_data, 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("rs.idle0", 64'(b32.out_valid), 64'd0);
    @(negedge clk);
    chk("rs.idle1", 64'(b32.out_valid), 64'd0);
    op(32'hFFFFFFF9, RM_RN, 32'hC0E00000, 1'b0, 64'hC01C000000000000, "rs.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
